swiss_timer_counter: RTL and testbench

SWISS_TIMER_COUNTER -- requirements
Module: swiss_timer_counter

---
 rtl/swiss_timer_counter.sv | 160 ++++++++++++++++
 tb/tb_swiss_timer_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/swiss_timer_counter.sv
// Stopwatch core: 0.01 s prescaler, four-digit BCD count 00.00..99.99,
// run/stop/lap/clear control and a lap-freezable display register.
module swiss_timer_counter #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_Stop,
  input  logic       lap,
  input  logic       clear,
  output logic [4:0] tens_Place,
  output logic [4:0] ones_Place,
  output logic [4:0] tenths_Place,
  output logic [4:0] hundredths_Place,
  output logic       running,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STOP = 3'd2,
    S_LAP  = 3'd3,
    S_MAX  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic [3:0][3:0]     r_cnt;   // [0]=hundredths .. [3]=tens
  logic [3:0][3:0]     r_disp;
  logic                r_blank;
  logic                r_running;
  logic                r_overflow;

  logic [3:0][3:0]     w_cnt_inc;
  logic                w_carry;
  logic                w_counting;
  logic                w_tick;
  logic                w_at_max;
  logic                w_max_hit;
  logic                w_clear_act;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == PRE_LAST);
  assign w_at_max   = (r_cnt == 16'h9999);
  assign w_max_hit  = w_tick && w_at_max;

  // BCD increment with ripple carry, all digits in one cycle
  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_cnt[i] == 4'd9) begin
          w_cnt_inc[i] = 4'd0;
        end else begin
          w_cnt_inc[i] = r_cnt[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: saturation beats any pulse; otherwise clear > start_Stop > lap
  always_comb begin
    w_state_nxt = r_state;
    w_clear_act = 1'b0;
    if (w_max_hit) begin
      w_state_nxt = S_MAX;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (clear)           w_clear_act = 1'b1;
          else if (start_Stop) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (start_Stop)      w_state_nxt = S_STOP;
          else if (lap)        w_state_nxt = S_LAP;
        end
        S_LAP: begin
          if (start_Stop)      w_state_nxt = S_STOP;
          else if (lap)        w_state_nxt = S_RUN;
        end
        S_STOP: begin
          if (clear) begin
            w_clear_act = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (start_Stop) begin
            w_state_nxt = S_RUN;
          end
        end
        S_MAX: begin
          if (clear) begin
            w_clear_act = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Prescaler and count; the count saturates at 99.99
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_clear_act) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_counting) begin
      if (w_tick) begin
        r_presc <= '0;
        if (!w_at_max) r_cnt <= w_cnt_inc;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Display follows the count except while a lap is frozen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp  <= '0;
      r_blank <= 1'b1;
    end else if (r_state != S_LAP) begin
      r_disp  <= r_cnt;
      r_blank <= (r_cnt[3] == 4'd0);
    end
  end

  // Status flags registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_running  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      r_overflow <= (w_state_nxt == S_MAX);
    end
  end

  assign tens_Place       = {r_blank, r_disp[3]};
  assign ones_Place       = {1'b0, r_disp[2]};
  assign tenths_Place     = {1'b0, r_disp[1]};
  assign hundredths_Place = {1'b0, r_disp[0]};
  assign running          = r_running;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_swiss_timer_counter.sv
// Bench for swiss_timer_counter: directed scenarios plus random pulses,
// checked against a count-in-hundredths reference model.
module tb_swiss_timer_counter;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       start_Stop;
  logic       lap;
  logic       clear;
  logic [4:0] tens_Place;
  logic [4:0] ones_Place;
  logic [4:0] tenths_Place;
  logic [4:0] hundredths_Place;
  logic       running;
  logic       overflow;

  swiss_timer_counter #(.TICK_DIV(DIV)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_Stop       (start_Stop),
    .lap              (lap),
    .clear            (clear),
    .tens_Place       (tens_Place),
    .ones_Place       (ones_Place),
    .tenths_Place     (tenths_Place),
    .hundredths_Place (hundredths_Place),
    .running          (running),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: count held as an integer number of hundredths
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3, M_MAX = 4;
  int m_st, m_cnt, m_pre, m_disp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_disp = 0;
  endtask

  task automatic model_step(input bit ss, input bit lp, input bit cl);
    int  nst;
    bit  counting;
    bit  sat;
    int  new_disp;
    counting = (m_st == M_RUN) || (m_st == M_LAP);
    new_disp = (m_st == M_LAP) ? m_disp : m_cnt;
    sat = 1'b0;
    nst = m_st;
    if (counting) begin
      if (m_pre == DIV - 1) begin
        m_pre = 0;
        if (m_cnt == 9999) sat = 1'b1;
        else               m_cnt = m_cnt + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (sat) nst = M_MAX;
    else begin
      case (m_st)
        M_IDLE: if (cl) begin m_cnt = 0; m_pre = 0; end else if (ss) nst = M_RUN;
        M_RUN:  if (ss) nst = M_STOP; else if (lp) nst = M_LAP;
        M_LAP:  if (ss) nst = M_STOP; else if (lp) nst = M_RUN;
        M_STOP: if (cl) begin m_cnt = 0; m_pre = 0; nst = M_IDLE; end
                else if (ss) nst = M_RUN;
        default: if (cl) begin m_cnt = 0; m_pre = 0; nst = M_IDLE; end
      endcase
    end
    m_st   = nst;
    m_disp = new_disp;
  endtask

  task automatic check_outputs(input string tag);
    int t;
    t = m_disp / 1000;
    chk({tag, "_tens"},  32'(tens_Place),       32'((t == 0) ? 16 + t : t));
    chk({tag, "_ones"},  32'(ones_Place),       32'((m_disp / 100) % 10));
    chk({tag, "_tnth"},  32'(tenths_Place),     32'((m_disp / 10) % 10));
    chk({tag, "_hund"},  32'(hundredths_Place), 32'(m_disp % 10));
    chk({tag, "_run"},   32'(running),          32'((m_st == M_RUN) || (m_st == M_LAP)));
    chk({tag, "_ovf"},   32'(overflow),         32'(m_st == M_MAX));
  endtask

  // One clock: inputs held across the edge, outputs sampled 1 ns after it
  task automatic cycle(input bit ss, input bit lp, input bit cl);
    start_Stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    model_step(ss, lp, cl);
    #1;
    check_outputs("cyc");
    start_Stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input int target, input int limit);
    int n;
    n = 0;
    while (m_cnt != target && n < limit) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_count", 32'(m_cnt), 32'(target));
  endtask

  // Asynchronous reset: outputs checked before any clock edge
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    start_Stop = 1'b0; lap = 1'b0; clear = 1'b0;
    reset_n = 1'b1;
    #2;
    apply_reset();

    // Start, 40 cycles of running, display at the following edge
    cycle(1'b1, 1'b0, 1'b0);
    idle(41);
    chk("r34_hund",  32'(hundredths_Place), 32'd0);
    chk("r34_tnth",  32'(tenths_Place),     32'd1);
    chk("r34_blank", 32'(tens_Place[4]),    32'd1);

    // 09.99 -> 10.00 carry through every digit
    run_until(999, 5000);
    run_until(1000, 8);
    idle(1);
    chk("r35_tens", 32'(tens_Place), 32'd1);
    chk("r35_ones", 32'(ones_Place), 32'd0);

    // Saturation at 99.99
    run_until(9998, 40000);
    idle(8);
    chk("r36_ovf",  32'(overflow), 32'd1);
    chk("r36_run",  32'(running),  32'd0);
    chk("r36_hund", 32'(hundredths_Place), 32'd9);
    cycle(1'b1, 1'b0, 1'b0);
    chk("r36_ovf_hold", 32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    idle(1);
    chk("r36_clr_tens", 32'(tens_Place), 32'd16);
    chk("r36_clr_ovf",  32'(overflow),   32'd0);

    // Lap freeze and release
    cycle(1'b1, 1'b0, 1'b0);
    run_until(5, 100);
    cycle(1'b0, 1'b1, 1'b0);
    run_until(20, 100);
    chk("r37_hold_hund", 32'(hundredths_Place), 32'd5);
    chk("r37_hold_tnth", 32'(tenths_Place),     32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    idle(1);
    chk("r37_live_tnth", 32'(tenths_Place),     32'd2);
    chk("r37_live_hund", 32'(hundredths_Place), 32'd0);

    // Clear ignored while running; start+clear in STOP clears
    cycle(1'b0, 1'b0, 1'b1);
    chk("r38_run_kept", 32'(running), 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    idle(1);
    chk("r38_tnth", 32'(tenths_Place), 32'd0);
    chk("r38_run",  32'(running),      32'd0);

    // Random pulse traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 31) == 0));
    end

    // Reset mid-tick at 12.34
    apply_reset();
    cycle(1'b1, 1'b0, 1'b0);
    run_until(1234, 6000);
    idle(2);
    chk("r39_pre_tens", 32'(tens_Place), 32'd1);
    #1;
    apply_reset();
    idle(10);
    chk("r39_after_hund", 32'(hundredths_Place), 32'd0);
    chk("r39_after_run",  32'(running),          32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
